// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// Sequencing controller for the EXU iterative divider: resolves RV64M corner cases
// locally, reuses the last quotient/remainder pair, and drives the divider handshake.
module ysyx_23060136_exu_div_ctrl #(
    parameter int TAG_W    = 5,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_word,
    input  logic [63:0]       in_src1,
    input  logic [63:0]       in_src2,
    input  logic [TAG_W-1:0]  in_tag,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_result,
    output logic [TAG_W-1:0]  out_tag,

    output logic              div_valid,
    input  logic              div_ready,
    output logic              div_divw,
    output logic              div_signed,
    output logic [63:0]       div_dividend,
    output logic [63:0]       div_divisor,
    input  logic              div_out_valid,
    input  logic [63:0]       div_quotient,
    input  logic [63:0]       div_remainder,

    output logic [2:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are both
    // high; valid never waits on ready, and payload is held stable while valid is high.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [1:0]  op_q;
    logic        word_q;
    logic [63:0] src1_q;
    logic [63:0] src2_q;

    logic        cache_valid_q;
    logic [63:0] key_src1_q;
    logic [63:0] key_src2_q;
    logic        key_word_q;
    logic        key_signed_q;
    logic [63:0] cache_quo_q;
    logic [63:0] cache_rem_q;

    logic        accept;
    logic        fast_path;
    logic        div_capture;

    logic        in_signed;
    logic        in_rem;
    logic        in_div_zero;
    logic        in_overflow;
    logic        in_hit;
    logic [63:0] in_dividend_eff;
    logic [63:0] in_corner_quo;
    logic [63:0] in_corner_rem;
    logic [63:0] in_fast_result;

    logic [63:0] div_quo_eff;
    logic [63:0] div_rem_eff;
    logic [63:0] div_result;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Corner-case and cache-hit resolution on the incoming op, used at acceptance.
    always_comb begin
        in_signed       = ~in_op[0];
        in_rem          = in_op[1];
        in_dividend_eff = in_word ? sext32(in_src1[31:0]) : in_src1;
        in_div_zero     = in_word ? (in_src2[31:0] == 32'd0) : (in_src2 == 64'd0);
        in_overflow     = in_signed &
                          (in_word ? ((in_src1[31:0] == 32'h8000_0000) &&
                                      (in_src2[31:0] == 32'hFFFF_FFFF))
                                   : ((in_src1 == 64'h8000_0000_0000_0000) &&
                                      (in_src2 == 64'hFFFF_FFFF_FFFF_FFFF)));
        in_hit          = CACHE_EN && cache_valid_q &&
                          (in_src1 == key_src1_q) && (in_src2 == key_src2_q) &&
                          (in_word == key_word_q) && (in_signed == key_signed_q);

        // Divide-by-zero yields all-ones / dividend; overflow yields dividend / zero.
        in_corner_quo   = in_div_zero ? 64'hFFFF_FFFF_FFFF_FFFF : in_dividend_eff;
        in_corner_rem   = in_div_zero ? in_dividend_eff : 64'd0;

        if (in_div_zero || in_overflow) begin
            in_fast_result = in_rem ? in_corner_rem : in_corner_quo;
        end else begin
            in_fast_result = in_rem ? cache_rem_q : cache_quo_q;
        end
    end

    // Divider results in word mode keep only the low word, sign-extended.
    always_comb begin
        div_quo_eff = word_q ? sext32(div_quotient[31:0])  : div_quotient;
        div_rem_eff = word_q ? sext32(div_remainder[31:0]) : div_remainder;
        div_result  = op_q[1] ? div_rem_eff : div_quo_eff;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        fast_path   = 1'b0;
        div_capture = 1'b0;
        in_ready    = (state_q == S_IDLE) & ~flush;
        div_valid   = (state_q == S_ISSUE) & ~flush;
        out_valid   = (state_q == S_HOLD) & ~flush;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (in_div_zero || in_overflow || in_hit) begin
                        fast_path = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (div_ready) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // The divider cannot be aborted, so a flush here must drain its result.
                if (div_out_valid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        div_capture = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q          <= 2'd0;
            word_q        <= 1'b0;
            src1_q        <= 64'd0;
            src2_q        <= 64'd0;
            out_result    <= 64'd0;
            out_tag       <= '0;
            cache_valid_q <= 1'b0;
            key_src1_q    <= 64'd0;
            key_src2_q    <= 64'd0;
            key_word_q    <= 1'b0;
            key_signed_q  <= 1'b0;
            cache_quo_q   <= 64'd0;
            cache_rem_q   <= 64'd0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                word_q  <= in_word;
                src1_q  <= in_src1;
                src2_q  <= in_src2;
                out_tag <= in_tag;
            end
            if (fast_path) begin
                out_result <= in_fast_result;
            end
            if (div_capture) begin
                out_result    <= div_result;
                cache_valid_q <= 1'b1;
                key_src1_q    <= src1_q;
                key_src2_q    <= src2_q;
                key_word_q    <= word_q;
                key_signed_q  <= ~op_q[0];
                cache_quo_q   <= div_quo_eff;
                cache_rem_q   <= div_rem_eff;
            end
        end
    end

    assign div_divw     = word_q;
    assign div_signed   = ~op_q[0];
    assign div_dividend = src1_q;
    assign div_divisor  = src2_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/ysyx_23060136_exu_div_ctrl.md
Name: ysyx_23060136_exu_div_ctrl

Overview:
Sequencing controller for the iterative 64-bit divider in EXU. It accepts decoded RV64M divide/remainder ops (DIV/DIVU/REM/REMU and their W forms) from the issue stage. It resolves RISC-V corner cases (divide-by-zero, signed overflow) without using the divider, and reuses the last quotient/remainder pair for back-to-back DIV+REM on identical operands. It drives the divider's valid/ready handshake and presents one result per op to the writeback side.

Parameters:
TAG_W, 5, width of destination-register tag carried with each op
CACHE_EN, 1, 1 enables the last-result reuse cache; 0 forces every non-corner op through the divider

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
flush  in  1  kill the in-flight op, e.g. on redirect or exception
in_valid  in  1  op request
in_ready  out  1  controller can accept an op
in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
in_word  in  1  W-form op (32-bit)
in_src1  in  64  dividend
in_src2  in  64  divisor
in_tag  in  TAG_W  destination tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  64  final rd value
out_tag  out  TAG_W  tag of result
div_valid  out  1  request to divider
div_ready  in  1  divider idle
div_divw  out  1  word mode to divider
div_signed  out  1  signed mode to divider
div_dividend  out  64  operand to divider
div_divisor  out  64  operand to divider
div_out_valid  in  1  divider completion, one-cycle pulse
div_quotient  in  64  divider quotient
div_remainder  in  64  divider remainder

Behaviour:
- Reset (rst==0 at posedge): state IDLE; out_valid=0; div_valid=0; cache invalid; out_result=0; out_tag=0. in_ready=1 from the first cycle after reset.
- States: IDLE, ISSUE, BUSY, DRAIN, HOLD.
- in_ready = (state==IDLE) & ~flush. Accept on in_valid & in_ready: register op, word flag, operands, and tag.
- Signed = ~in_op[0]. Effective operands:
  - Word: low 32 bits only.
  - Zero test: W form checks src2[31:0]==0; 64-bit form checks src2==0.
  - Overflow test (signed only): W form is src1[31:0]==0x8000_0000 & src2[31:0]==0xFFFF_FFFF; 64-bit form is src1==0x8000…0 & src2==all-ones.
- Corner results, computed at acceptance; next state HOLD, divider untouched:
  - Divide-by-zero: quotient=all-ones; remainder=dividend.
  - Signed overflow: quotient=dividend; remainder=0.
  - W forms: 32-bit result, then sign-extended from bit 31.
- Cache hit (CACHE_EN, cache valid, and src1, src2, word, signed all equal the stored key): result taken from the stored quotient/remainder selected by in_op[1]; next state HOLD. The cache is not modified.
- Otherwise: next state ISSUE.
  - In ISSUE, div_valid=1 with the registered operands, div_divw=word, div_signed=signed.
  - On div_valid & div_ready, go to BUSY; stay in ISSUE while div_ready=0.
- BUSY: wait for div_out_valid.
  - Capture quotient/remainder. For W forms, use bits [31:0] sign-extended from bit 31 (higher divider bits are ignored).
  - Store key plus both results in the cache and set it valid.
  - Select the result by op; go to HOLD.
- HOLD: out_valid=1 with out_result/out_tag stable until out_ready. On out_valid & out_ready, go to IDLE; in_ready is high the following cycle (no same-cycle accept).
- Latency: out_valid rises 1 cycle after acceptance for corner/hit ops. For divider ops it rises 1 cycle after the div_out_valid pulse.
- Flush, highest priority:
  - In IDLE/ISSUE/HOLD: go to IDLE next cycle, out_valid=0, div_valid dropped.
  - In BUSY: go to DRAIN (the divider cannot be aborted). DRAIN waits for div_out_valid, discards the result without a cache update, then goes to IDLE.
  - Flush in the same cycle as div_out_valid in BUSY: the result is discarded, go to IDLE directly.
- Reset mid-operation returns to IDLE immediately. The divider is reset by the same reset domain.
- div_valid is never asserted outside ISSUE; at most one op is outstanding at the divider.

Test Plan:
- DIVU 64-bit, src1=100, src2=7 -> div_valid handshake in ISSUE, out_result=14 one cycle after div_out_valid; then REMU with the same operands -> cache hit, out_result=2 one cycle after acceptance, div_valid stays 0.
- DIVW src1=0xFFFF_FFFF_FFFF_FFF9 (-7), src2=2 -> out_result=0xFFFF_FFFF_FFFF_FFFD (-3); REMW same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1) via cache.
- DIV src2=0, src1=0x1234 -> out_result=0xFFFF_FFFF_FFFF_FFFF at 1-cycle latency; REM -> 0x1234; REMW src1=0x8000_0000, src2=0 -> 0xFFFF_FFFF_8000_0000.
- DIV src1=0x8000_0000_0000_0000, src2=-1 -> out_result=0x8000_0000_0000_0000; REMW src1=0x8000_0000, src2=0xFFFF_FFFF -> 0; divider never requested.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_result/out_tag stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Flush in BUSY -> state DRAIN, no out_valid. After div_out_valid: IDLE, cache unchanged (a repeat op misses and reissues). A flush coinciding with in_valid -> op not accepted.
